// File: rtl/mips_fwd_hazard_unit_if.sv
// Port bundle between the pipeline datapath and the forwarding/hazard unit.
// The datapath side is the master; the unit itself is the slave.
interface mips_fwd_hazard_unit_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [4:0]             id_rs;
    logic [4:0]             id_rt;
    logic                   id_uses_rs;
    logic                   id_uses_rt;
    logic [4:0]             id_dest;
    logic                   id_reg_write;
    logic                   id_mem_read;
    logic                   ex_branch_taken;
    logic [1:0]             fwd_a;
    logic [1:0]             fwd_b;
    logic                   stall;
    logic                   pc_write;
    logic                   ifid_write;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_reg_write, id_mem_read, ex_branch_taken,
        input  fwd_a, fwd_b, stall, pc_write, ifid_write, flush, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_reg_write, id_mem_read, ex_branch_taken,
        output fwd_a, fwd_b, stall, pc_write, ifid_write, flush, stall_count
    );
endinterface

// File: rtl/mips_fwd_hazard_unit.sv
// Forwarding-select and load-use/branch hazard control for the 5-stage MIPS core.
// Shadows the destination tags of the EX, MEM and WB stages alongside the real pipeline registers.
module mips_fwd_hazard_unit #(
    parameter int STALL_CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    mips_fwd_hazard_unit_if.slave bus
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    slot_t                  ex_q, mem_q, wb_q, ex_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   load_use;
    logic                   stall_i;
    logic                   unused_slot_bits;

    // A slot can supply a value for register r only if it really writes a non-zero r.
    function automatic logic writes(input slot_t s, input logic [4:0] r);
        return s.valid && s.reg_write && (s.dest != 5'd0) && (s.dest == r);
    endfunction

    function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem,
                                           input slot_t wb, input logic [4:0] src);
        if (!ex.valid)           return 2'd0;
        else if (writes(mem, src)) return 2'd2;
        else if (writes(wb, src))  return 2'd1;
        else                     return 2'd0;
    endfunction

    always_comb begin
        load_use = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dest != 5'd0) &&
                   ((bus.id_uses_rs && (ex_q.dest == bus.id_rs)) ||
                    (bus.id_uses_rt && (ex_q.dest == bus.id_rt)));
        // A taken branch discards the ID instruction, so its hazard is moot.
        stall_i  = load_use && !bus.ex_branch_taken;
    end

    always_comb begin
        ex_d = '0;
        if (bus.id_valid && !stall_i && !bus.ex_branch_taken) begin
            ex_d.valid     = 1'b1;
            ex_d.rs        = bus.id_rs;
            ex_d.rt        = bus.id_rt;
            ex_d.dest      = bus.id_dest;
            ex_d.reg_write = bus.id_reg_write;
            ex_d.mem_read  = bus.id_mem_read;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
            if (stall_i && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.fwd_a       = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs);
    assign bus.fwd_b       = fwd_sel(ex_q, mem_q, wb_q, ex_q.rt);
    assign bus.stall       = stall_i;
    assign bus.pc_write    = !stall_i;
    assign bus.ifid_write  = !stall_i;
    assign bus.flush       = bus.ex_branch_taken;
    assign bus.stall_count = stall_cnt_q;

    // Source tags and load flag retire with the WB slot without further use.
    assign unused_slot_bits = ^{wb_q.rs, wb_q.rt, wb_q.mem_read};
endmodule
